// File: rtl/obi_data_responder.sv
// obi_data_responder
//   OBI data-side memory responder. Grants requests after a programmable
//   stall, accesses a byte-enabled word RAM at the grant edge, and returns the
//   response through a fixed-latency delay line, strictly in grant order.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   req_i / gnt_o  OBI address-phase handshake (gnt_o is combinational)
//   addr_i         byte address, bits [1:0] ignored
//   we_i, be_i     write enable, byte enables
//   wdata_i        write data
//   rvalid_o       response valid (never stalled, no rready)
//   rdata_o        read data; 0 for writes, errors and when rvalid_o=0
//   err_o          out-of-range error, qualified by rvalid_o
//   outstanding_o  granted transactions still awaiting a response
module obi_data_responder #(
    parameter int unsigned RAM_ADDR_WIDTH  = 20,
    parameter int unsigned GNT_DELAY       = 0,
    parameter int unsigned RESP_DELAY      = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [3:0]  outstanding_o
);

    localparam int unsigned WORDS = 2 ** (RAM_ADDR_WIDTH - 2);
    localparam logic [3:0]  GD    = 4'(GNT_DELAY);
    localparam logic [3:0]  MAXO  = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, GRANT = 2'd2} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] outstanding_q, outstanding_d;

    logic [RESP_DELAY-1:0]        vld_pipe_q;
    logic [RESP_DELAY-1:0][31:0]  rdata_pipe_q;
    logic [RESP_DELAY-1:0]        err_pipe_q;

    logic [31:0] mem_q [WORDS];

    logic                      grant;
    logic                      can_accept;
    logic                      rv_last;
    logic                      in_range;
    logic [RAM_ADDR_WIDTH-3:0] widx;
    logic                      unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];
    assign in_range   = (addr_i[31:RAM_ADDR_WIDTH] == '0);
    assign widx       = addr_i[RAM_ADDR_WIDTH-1:2];
    assign rv_last    = vld_pipe_q[RESP_DELAY-1];
    // A response leaving this cycle frees a slot for a grant in the same cycle.
    assign can_accept = (outstanding_q < MAXO) | rv_last;

    // Grant FSM. With GNT_DELAY>0 a grant drops straight back into WAIT with
    // cnt=1, so back-to-back requests are spaced GNT_DELAY cycles apart while a
    // fresh request from IDLE needs GNT_DELAY+1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            WAIT: begin
                if (!req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= GD) begin
                    cnt_d = GD;  // saturate while blocked by the outstanding limit
                    if (can_accept) begin
                        grant = 1'b1;
                        cnt_d = 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin  // IDLE, GRANT
                state_d = IDLE;
                cnt_d   = '0;
                if (req_i) begin
                    if (GNT_DELAY == 0) begin
                        if (can_accept) begin
                            grant   = 1'b1;
                            state_d = GRANT;
                        end
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
        endcase
        if (rst_i) grant = 1'b0;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({grant, rv_last})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Response delay line; read data is captured at the grant edge so a later
    // write to the same word cannot leak into this response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe_q   <= '0;
            rdata_pipe_q <= '0;
            err_pipe_q   <= '0;
        end else begin
            vld_pipe_q[0]   <= grant;
            rdata_pipe_q[0] <= (grant && !we_i && in_range) ? mem_q[widx] : 32'h0;
            err_pipe_q[0]   <= grant & ~in_range;
            for (int i = 1; i < int'(RESP_DELAY); i++) begin
                vld_pipe_q[i]   <= vld_pipe_q[i-1];
                rdata_pipe_q[i] <= rdata_pipe_q[i-1];
                err_pipe_q[i]   <= err_pipe_q[i-1];
            end
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (grant && we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[widx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Outputs are forced quiet for the whole reset cycle, including a response
    // that would otherwise leave the delay line in that cycle.
    assign gnt_o         = grant;
    assign rvalid_o      = rv_last & ~rst_i;
    assign rdata_o       = rst_i ? 32'h0 : rdata_pipe_q[RESP_DELAY-1];
    assign err_o         = err_pipe_q[RESP_DELAY-1] & ~rst_i;
    assign outstanding_o = rst_i ? 4'h0 : outstanding_q;

endmodule

// File: tb/tb_obi_data_responder.sv
// Randomized bench for obi_data_responder. Two instances with different
// stall/latency settings are driven independently and compared every cycle
// against a transaction-level model: grant timing from request age, responses
// from a due-time queue, RAM from a small word array.
module tb_obi_data_responder;

  localparam int RW [2] = '{20, 12};
  localparam int GD [2] = '{0, 3};
  localparam int RD [2] = '{1, 4};
  localparam int MX [2] = '{2, 2};
  localparam int NSCR   = 16;
  localparam int NCYC   = 1500;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        we    [2];
  logic [3:0]  be    [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic [3:0]  outst [2];

  always #5 clk = ~clk;

  obi_data_responder #(.RAM_ADDR_WIDTH(20), .GNT_DELAY(0), .RESP_DELAY(1), .MAX_OUTSTANDING(2)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .outstanding_o(outst[0]));

  obi_data_responder #(.RAM_ADDR_WIDTH(12), .GNT_DELAY(3), .RESP_DELAY(4), .MAX_OUTSTANDING(2)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .outstanding_o(outst[1]));

  // model state
  txn_t        scr [NSCR];
  resp_t       rb [2][16];
  int          rb_head [2];
  int          rb_cnt  [2];
  logic [31:0] mref [2][8];
  int          age   [2];
  bit          fresh [2];
  bit          busy  [2];
  int          pos   [2];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input int k);
    int r;
    if (busy[k]) return;
    if (pos[k] < NSCR) begin
      we[k] = scr[pos[k]].we; addr[k] = scr[pos[k]].addr;
      wdata[k] = scr[pos[k]].wdata; be[k] = scr[pos[k]].be;
      pos[k]++;
      req[k] = 1'b1; busy[k] = 1'b1;
      return;
    end
    r = $urandom_range(0, 7);
    if (r == 7) begin
      req[k] = 1'b0;
      return;
    end
    we[k]   = (r == 3 || r == 4 || r == 6);
    addr[k] = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
    if (r >= 5) addr[k] = addr[k] | (32'h1 << $urandom_range(RW[k], 31));
    be[k]    = 4'($urandom_range(0, 15));
    wdata[k] = $urandom;
    req[k]   = 1'b1;
    busy[k]  = 1'b1;
  endtask

  task automatic step(input int k, input int t);
    bit          due, eg, inr;
    int          thr, idx;
    logic [31:0] erd;
    logic        eerr;
    string       p;
    p = $sformatf("u%0d c%0d", k, t);
    if (rst) begin
      chk({p, " rst gnt"}, gnt[k], 0);
      chk({p, " rst rvalid"}, rvalid[k], 0);
      chk({p, " rst rdata"}, rdata[k], 0);
      chk({p, " rst err"}, err[k], 0);
      chk({p, " rst outstanding"}, outst[k], 0);
      rb_cnt[k] = 0; age[k] = 0; fresh[k] = 1'b1;
      return;
    end
    due  = (rb_cnt[k] > 0) && (rb[k][rb_head[k]].due == t);
    erd  = due ? rb[k][rb_head[k]].rdata : 32'h0;
    eerr = due ? rb[k][rb_head[k]].err : 1'b0;
    chk({p, " outstanding"}, outst[k], rb_cnt[k]);
    chk({p, " rvalid"}, rvalid[k], due);
    chk({p, " rdata"}, rdata[k], erd);
    chk({p, " err"}, err[k], eerr);
    if (req[k]) begin
      age[k]++;
      thr = fresh[k] ? GD[k] + 1 : (GD[k] > 0 ? GD[k] : 1);
      eg  = (rb_cnt[k] < MX[k] || due) && age[k] >= thr;
    end else begin
      age[k] = 0; fresh[k] = 1'b1; eg = 1'b0;
    end
    chk({p, " gnt"}, gnt[k], eg);
    if (due) begin
      rb_head[k] = (rb_head[k] + 1) % 16;
      rb_cnt[k]--;
    end
    if (eg) begin
      inr = ((addr[k] >> RW[k]) == 0);
      idx = int'(addr[k][4:2]);
      erd = 32'h0;
      if (we[k] && inr) begin
        for (int b = 0; b < 4; b++)
          if (be[k][b]) mref[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
      end else if (!we[k] && inr) begin
        erd = mref[k][idx];
      end
      rb[k][(rb_head[k] + rb_cnt[k]) % 16] = '{t + RD[k], erd, !inr};
      rb_cnt[k]++;
      age[k] = 0; fresh[k] = 1'b0; busy[k] = 1'b0;
    end
  endtask

  initial begin
    scr[0] = '{1'b1, 32'h0000_0100, 32'hA5A5_1234, 4'hF};
    scr[1] = '{1'b0, 32'h0000_0100, 32'h0, 4'hF};
    scr[2] = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'b0010};
    scr[3] = '{1'b0, 32'h0000_0100, 32'h0, 4'hF};
    scr[4] = '{1'b0, 32'h0010_0000, 32'h0, 4'hF};
    scr[5] = '{1'b1, 32'h0010_0100, 32'hDEAD_BEEF, 4'hF};
    scr[6] = '{1'b0, 32'h0000_0100, 32'h0, 4'hF};
    scr[7] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'h0};
    scr[8] = '{1'b0, 32'h0000_0100, 32'h0, 4'hF};
    for (int i = 1; i < 8; i++)
      scr[8 + i] = '{1'b1, 32'h100 + 32'(4 * i), 32'h0102_0304 * 32'(i), 4'hF};
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; be[k] = '0; wdata[k] = '0;
      rb_head[k] = 0; rb_cnt[k] = 0; age[k] = 0; fresh[k] = 1'b1; busy[k] = 1'b0; pos[k] = 0;
      for (int w = 0; w < 8; w++) mref[k][w] = '0;
    end
    rst = 1'b1;
    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk);
      #1;
      rst = (t < 3) || (t == 400) || (t == 801) || (t == 1150);
      if (t >= 3) begin
        drive(0);
        drive(1);
      end
      @(negedge clk);
      step(0, t);
      step(1, t);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
